// File: rtl/ula_seq_if.sv
// ula_seq_if: request/result handshake bundle between the operand datapath and ula_seq
interface ula_seq_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [3:0]         Sel;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] S;
  logic               Z;
  logic               C;
  logic               DZ;
  modport master (
    output in_valid, Sel, A, B, out_ready,
    input  in_ready, out_valid, S, Z, C, DZ
  );
  modport slave (
    input  in_valid, Sel, A, B, out_ready,
    output in_ready, out_valid, S, Z, C, DZ
  );
endinterface

// File: rtl/ula_seq.sv
// ula_seq: multi-cycle ALU with iterative shift-add multiply and restoring divide behind valid/ready
module ula_seq #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst_n,
  ula_seq_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t          state;
  logic [W2-1:0]   work;
  logic [W2-1:0]   s_q;
  logic [W2-1:0]   alu_s;
  logic [W2-1:0]   mul_next;
  logic [W2-1:0]   div_next;
  logic [W2-1:0]   iter_next;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_next;
  logic [CW-1:0]   cnt;
  logic [WIDTH:0]  add_w;
  logic [WIDTH:0]  mul_sum;
  logic [WIDTH:0]  div_sh;
  logic [WIDTH:0]  div_diff;
  logic            out_valid_q;
  logic            z_q;
  logic            c_q;
  logic            dz_q;
  logic            alu_c;
  logic            alu_dz;
  logic            last;
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = out_valid_q;
  assign bus.S         = s_q;
  assign bus.Z         = z_q;
  assign bus.C         = c_q;
  assign bus.DZ        = dz_q;
  assign add_w = {1'b0, bus.A} + {1'b0, bus.B};
  // Multiply step: conditionally add B into the upper half, then shift the whole product right.
  assign mul_sum  = {1'b0, work[W2-1:WIDTH]} + (work[0] ? {1'b0, b_q} : '0);
  assign mul_next = {mul_sum, work[WIDTH-1:1]};
  // Divide step: work holds {remainder, dividend}; shift one dividend bit in and trial-subtract B.
  assign div_sh   = work[W2-1:WIDTH-1];
  assign div_diff = div_sh - {1'b0, b_q};
  assign rem_next = div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign div_next = {rem_next, work[WIDTH-2:0], ~div_diff[WIDTH]};
  assign iter_next = (state == MUL) ? mul_next : div_next;
  assign last      = cnt == CW'(WIDTH - 1);
  // Single-cycle results for every opcode that does not need the iterative engines.
  always_comb begin
    alu_s  = '0;
    alu_c  = 1'b0;
    alu_dz = 1'b0;
    case (bus.Sel)
      4'b0000: begin
        alu_s = {{(WIDTH-1){1'b0}}, add_w};
        alu_c = add_w[WIDTH];
      end
      4'b0001: begin
        alu_s = {{WIDTH{1'b0}}, bus.A} - {{WIDTH{1'b0}}, bus.B};
        alu_c = bus.A < bus.B;
      end
      4'b0011: begin
        alu_s  = {bus.A, {WIDTH{1'b1}}};
        alu_dz = 1'b1;
      end
      4'b0100: begin
        alu_s = {{(WIDTH-1){1'b0}}, bus.A, 1'b0};
        alu_c = bus.A[WIDTH-1];
      end
      4'b0101: begin
        alu_s = {{WIDTH{1'b0}}, bus.A >> 1};
        alu_c = bus.A[0];
      end
      4'b0110: alu_s = {{WIDTH{1'b0}}, bus.A[WIDTH-2:0], bus.A[WIDTH-1]};
      4'b0111: alu_s = {{WIDTH{1'b0}}, bus.A[0], bus.A[WIDTH-1:1]};
      4'b1000: alu_s = {{WIDTH{1'b0}}, bus.A & bus.B};
      4'b1001: alu_s = {{WIDTH{1'b0}}, bus.A | bus.B};
      4'b1010: alu_s = {{WIDTH{1'b0}}, bus.A ^ bus.B};
      4'b1011: alu_s = {{WIDTH{1'b0}}, ~(bus.A | bus.B)};
      4'b1100: alu_s = {{WIDTH{1'b0}}, ~(bus.A & bus.B)};
      4'b1101: alu_s = {{WIDTH{1'b0}}, ~(bus.A ^ bus.B)};
      4'b1110: alu_s = {{(W2-1){1'b0}}, bus.A > bus.B};
      4'b1111: alu_s = {{(W2-1){1'b0}}, bus.A == bus.B};
      default: alu_s = '0;
    endcase
  end
  // Control FSM: accept in IDLE, iterate in MUL/DIV, hold the registered result in DONE until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      work        <= '0;
      b_q         <= '0;
      cnt         <= '0;
      s_q         <= '0;
      out_valid_q <= 1'b0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          work <= {{WIDTH{1'b0}}, bus.A};
          b_q  <= bus.B;
          cnt  <= '0;
          if (bus.Sel == 4'b0010) state <= MUL;
          else if (bus.Sel == 4'b0011 && bus.B != '0) state <= DIV;
          else begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            s_q         <= alu_s;
            z_q         <= alu_s == '0;
            c_q         <= alu_c;
            dz_q        <= alu_dz;
          end
        end
        MUL, DIV: begin
          work <= iter_next;
          cnt  <= cnt + CW'(1);
          if (last) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            s_q         <= iter_next;
            z_q         <= iter_next == '0;
            c_q         <= 1'b0;
            dz_q        <= 1'b0;
          end
        end
        DONE: if (bus.out_ready) begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
Parametrised, multi-cycle successor to the team's 8-bit combinational ALU.
- Keeps the same 16-opcode Sel map at WIDTH bits.
- Registers every result behind a valid/ready handshake and adds Z, C and DZ flags.
- Replaces combinational multiply and divide with iterative shift-add and restoring-division engines (quotient plus remainder).
- Sits between the operand/control datapath and the result writeback stage.

Parameters:
WIDTH, 8, operand width in bits; result width is 2*WIDTH; must be ≥ 2.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operation request valid.
in_ready  output  1  block can accept; equals (state == IDLE).
Sel  input  4  opcode, sampled at accept.
A  input  WIDTH  operand A, sampled at accept.
B  input  WIDTH  operand B, sampled at accept.
out_valid  output  1  result valid; held until consumed.
out_ready  input  1  consumer accepts result.
S  output  2*WIDTH  registered result.
Z  output  1  S == 0.
C  output  1  carry / borrow / shifted-out bit.
DZ  output  1  divide by zero.

Behaviour:
- Reset (rst_n low, any time, including mid-operation):
  - State goes to IDLE.
  - out_valid=0, S=0, Z=0, C=0, DZ=0; iteration counter and operand registers cleared.
  - in_ready reads 1, but no accept occurs while rst_n is low.
  - An operation in progress is discarded and no result is produced.
- States: IDLE, MUL, DIV, DONE.
- Accept: in_valid && in_ready on a rising edge.
  - A, B and Sel are latched; later input changes are ignored.
- State transitions:
  - IDLE: on accept with Sel=0010, go to MUL; with Sel=0011 and B≠0, go to DIV; otherwise compute and go to DONE. Latency 1: out_valid rises on the edge after accept.
  - MUL: shift-add, one bit per cycle, WIDTH iterations. out_valid asserts exactly WIDTH+1 cycles after accept.
  - DIV: restoring division, one quotient bit per cycle, WIDTH iterations. Same latency as MUL.
  - DONE: out_valid=1; S, Z, C and DZ are stable. On out_valid && out_ready, return to IDLE; in_ready=1 on the next cycle. No accept is possible in DONE, so the minimum issue interval is 2 cycles.
- Results: unused upper bits of S are 0 unless stated otherwise.
  - 0000 ADD: S = A+B in WIDTH+1 bits; C = carry out (bit WIDTH).
  - 0001 SUB: S = (A−B) mod 2^(2*WIDTH); negative results fill the upper bits with 1s. C = borrow (A<B).
  - 0010 MUL: S = A*B, full 2*WIDTH bits; C=0.
  - 0011 DIV: S = {remainder, quotient}, remainder in the upper WIDTH bits; C=0.
  - 0011 DIV with B==0: no iteration, latency 1. S = {A, all ones}; DZ=1.
  - 0100 SHL: S = {A,1'b0} (WIDTH+1 bits); C = A[WIDTH-1].
  - 0101 SHR: S = A>>1; C = A[0].
  - 0110 ROL: S = {A[WIDTH-2:0], A[WIDTH-1]}; C=0.
  - 0111 ROR: S = {A[0], A[WIDTH-1:1]}; C=0.
  - 1000–1101 (AND, OR, XOR, NOR, NAND, XNOR): WIDTH-bit result, upper WIDTH bits 0; C=0.
  - 1110 GT: S = (A>B) ? 1 : 0.
  - 1111 EQ: S = (A==B) ? 1 : 0.
- Flags:
  - Z = (S==0), registered with S.
  - DZ=0 for every case except DIV with B==0.
- All comparisons and arithmetic are unsigned except the SUB wrap.
- S and the flags change only on entry to DONE or on reset; they hold their last values while in IDLE.
- Simultaneous in_valid with a pending result: not accepted until the result is consumed.

Test Plan (WIDTH=8):
- ADD A=200, B=100, out_ready=1 → out_valid one cycle after accept; S=0x012C, C=1, Z=0.
- MUL A=255, B=255 → out_valid exactly 9 cycles after accept; S=0xFE01; in_ready=0 throughout.
- DIV A=200, B=7 → after 9 cycles S=0x041C (quotient 28, remainder 4), DZ=0. DIV A=5, B=0 → latency 1; S=0x05FF, DZ=1.
- SUB A=5, B=10 → S=0xFFFB, C=1. ROL A=0x81 → S=0x0003. EQ A=B=0x3C → S=1. XOR A=B → S=0, Z=1.
- Backpressure: ADD 1+1 with out_ready=0 for 5 cycles → S=0x0002 and out_valid held stable, in_ready=0. Raise out_ready → in_ready=1 on the next cycle; a new op is accepted after that.
- Reset mid-MUL: accept 0x0F*0x0F, pull rst_n low 3 cycles later → out_valid=0 and S=0 immediately (asynchronous). After release, in_ready=1 and no result appears.
